// File: rtl/exu_div_pkg.sv
// exu_div_pkg: shared definitions for the execute-stage divide/remainder unit.
//   - div_state_e : FSM states (IDLE / CALC / DONE)
//   - special-case constants (all-ones quotient, INT64_MIN, INT32_MIN)
//   - DIV_WIDTH / DIV_CNT_W : default datapath and iteration-counter widths
//   - sext32() : sign-extend a 32-bit W-op result to 64 bits
package exu_div_pkg;

    localparam int DIV_WIDTH = 64;
    localparam int DIV_CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [63:0] QUO_ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT64_MIN    = 64'h8000_0000_0000_0000;
    localparam logic [31:0] INT32_MIN    = 32'h8000_0000;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

// File: rtl/exu_div_if.sv
// exu_div_if: request/response handshake bundle between decode/pipeline
// control and the divide unit.
//   request : in_valid, in_ready, op1, op2, div_signed, is_rem, inst_32bit
//   response: out_valid, out_ready, result
// Modports: master = pipeline side, slave = divider.
interface exu_div_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             div_signed;
    logic             is_rem;
    logic             inst_32bit;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, op1, op2, div_signed, is_rem, inst_32bit, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op1, op2, div_signed, is_rem, inst_32bit, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/div_iter_step.sv
// div_iter_step: one combinational restoring-division step.
//   rem      : current partial remainder (always < divisor)
//   in_bit   : next dividend bit shifted into the partial remainder
//   divisor  : unsigned divisor
//   rem_next : partial remainder after the trial subtraction
//   q_bit    : quotient bit produced by this step
module div_iter_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             in_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    // One extra bit so the shifted remainder never overflows; bit WIDTH of
    // the difference is the borrow of the trial subtraction.
    assign partial  = {rem, in_bit};
    assign diff     = partial - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
endmodule

// File: rtl/exu_div.sv
// exu_div: iterative radix-2 restoring divide/remainder unit (RV64 M ext).
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   flush     : drop any in-flight or completed operation
//   io        : exu_div_if.slave request/response handshake
//   busy      : unit is not IDLE
// Optional (macro EXU_DIV_PERF_CNT_EN):
//   perf_ops    : completed result handshakes
//   perf_cycles : CALC cycles spent by completed operations
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request (in_ready=1)
// CALC  | one quotient bit per cycle, N = 32 (W-op) or WIDTH cycles
// DONE  | result held with out_valid=1 until out_ready
module exu_div
    import exu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    exu_div_if.slave    io,
    output logic        busy
`ifdef EXU_DIV_PERF_CNT_EN
    ,
    output logic [63:0] perf_ops,
    output logic [63:0] perf_cycles
`endif
);
    div_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo_r, rem_r, dsr_r, result_r;
    logic             neg_q_r, neg_r_r, is_rem_r, w_r;

    logic             accept, last;
    logic             sa, sb, div0, ovf, special;
    logic [31:0]      a32_abs, b32_abs;
    logic [WIDTH-1:0] a64_abs, b64_abs, quo_init, b_abs, a_ext, res_spec;
    logic [WIDTH-1:0] step_rem, q_fin, sel, res_fin;
    logic             step_q;

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.result    = result_r;
    assign busy         = (state != IDLE);

    assign accept = io.in_valid & io.in_ready & ~flush;
    assign last   = (cnt == CNT_W'(1));

    // Operand preparation: W-ops use bit 31 as the sign bit.
    assign sa = io.div_signed & (io.inst_32bit ? io.op1[31] : io.op1[WIDTH-1]);
    assign sb = io.div_signed & (io.inst_32bit ? io.op2[31] : io.op2[WIDTH-1]);

    assign a32_abs = sa ? (~io.op1[31:0] + 32'd1) : io.op1[31:0];
    assign b32_abs = sb ? (~io.op2[31:0] + 32'd1) : io.op2[31:0];
    assign a64_abs = sa ? (~io.op1 + WIDTH'(1)) : io.op1;
    assign b64_abs = sb ? (~io.op2 + WIDTH'(1)) : io.op2;

    // A W-op dividend sits in the top half so the same MSB-first shift
    // consumes it in 32 steps and leaves the quotient in the low half.
    assign quo_init = io.inst_32bit ? {a32_abs, {(WIDTH-32){1'b0}}} : a64_abs;
    assign b_abs    = io.inst_32bit ? {{(WIDTH-32){1'b0}}, b32_abs} : b64_abs;

    assign div0 = io.inst_32bit ? (io.op2[31:0] == 32'd0) : (io.op2 == '0);
    assign ovf  = io.div_signed &
                  (io.inst_32bit ? ((io.op1[31:0] == INT32_MIN) && (io.op2[31:0] == 32'hFFFF_FFFF))
                                 : ((io.op1 == INT64_MIN) && (io.op2 == QUO_ALL_ONES)));
    assign special = div0 | ovf;

    assign a_ext    = io.inst_32bit ? sext32(io.op1[31:0]) : io.op1;
    assign res_spec = div0 ? (io.is_rem ? a_ext : QUO_ALL_ONES)
                           : (io.is_rem ? '0 : a_ext);

    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .in_bit   (quo_r[WIDTH-1]),
        .divisor  (dsr_r),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Sign fix and W-op extension applied to the last step's outputs so the
    // finished result is registered on the CALC -> DONE edge.
    assign q_fin   = {quo_r[WIDTH-2:0], step_q};
    assign sel     = is_rem_r ? (neg_r_r ? -step_rem : step_rem)
                              : (neg_q_r ? -q_fin : q_fin);
    assign res_fin = w_r ? sext32(sel[31:0]) : sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (io.in_valid) state_nxt = special ? DONE : CALC;
                CALC:    if (last)        state_nxt = DONE;
                DONE:    if (io.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            quo_r    <= '0;
            rem_r    <= '0;
            dsr_r    <= '0;
            result_r <= '0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            is_rem_r <= 1'b0;
            w_r      <= 1'b0;
        end else if (accept) begin
            cnt      <= io.inst_32bit ? CNT_W'(32) : CNT_W'(WIDTH);
            quo_r    <= quo_init;
            rem_r    <= '0;
            dsr_r    <= b_abs;
            neg_q_r  <= sa ^ sb;
            neg_r_r  <= sa;
            is_rem_r <= io.is_rem;
            w_r      <= io.inst_32bit;
            if (special) result_r <= res_spec;
        end else if (state == CALC && !flush) begin
            quo_r <= q_fin;
            rem_r <= step_rem;
            cnt   <= cnt - CNT_W'(1);
            if (last) result_r <= res_fin;
        end
    end

`ifdef EXU_DIV_PERF_CNT_EN
    // Cycles are credited at the result handshake so a flushed operation
    // never shows up in either counter.
    logic iter_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iter_r      <= 1'b0;
            perf_ops    <= '0;
            perf_cycles <= '0;
        end else begin
            if (accept) iter_r <= ~special;
            if (state == DONE && io.out_ready && !flush) begin
                perf_ops <= perf_ops + 64'd1;
                if (iter_r) perf_cycles <= perf_cycles + (w_r ? 64'd32 : 64'(WIDTH));
            end
        end
    end
`endif

endmodule

// File: tb/tb_exu_div.sv
module tb_exu_div;
    import exu_div_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic busy;
`ifdef EXU_DIV_PERF_CNT_EN
    logic [63:0] perf_ops, perf_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    exu_div_if #(.WIDTH(64)) dif ();

    exu_div dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .io          (dif),
        .busy        (busy)
`ifdef EXU_DIV_PERF_CNT_EN
        ,
        .perf_ops    (perf_ops),
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Drive a request at the falling edge and return just after the rising
    // edge that accepts it.
    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic sgn, input logic rem, input logic w);
        @(negedge clk);
        dif.op1 = a; dif.op2 = b;
        dif.div_signed = sgn; dif.is_rem = rem; dif.inst_32bit = w;
        dif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        dif.op1 = 64'hA5A5_A5A5_A5A5_A5A5;
        dif.op2 = 64'h5A5A_5A5A_5A5A_5A5A;
    endtask

    // Cycles from acceptance until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!dif.out_valid && lat < 200);
    endtask

    task automatic take_out();
        @(negedge clk);
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        dif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if (dif.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", dif.in_ready); end
        n_tests++;
        if (dif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", dif.out_valid); end
        n_tests++;
        if (dif.result !== 64'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", dif.result); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_basic_ops();
        logic [63:0] va [9] = '{64'd100, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9,
                                64'hDEAD_BEEF_FFFF_FFEC, 64'hDEAD_BEEF_FFFF_FFEC, 64'h1234_5678_FFFF_FFFF,
                                64'd1000, 64'd7};
        logic [63:0] vb [9] = '{64'd7, 64'd7, 64'd2, 64'd2,
                                64'h1234_0000_0000_0003, 64'h1234_0000_0000_0003, 64'h0000_0001_0000_0001,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'd1000};
        logic        vs [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        vr [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        vw [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [63:0] ve [9] = '{64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF,
                                64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                                64'hFFFF_FFFF_FFFF_FC18, 64'd7};
        int          vl [9] = '{65, 65, 65, 65, 33, 33, 33, 65, 65};
        int lat;
        for (int i = 0; i < 9; i++) begin
            issue(va[i], vb[i], vs[i], vr[i], vw[i]);
            wait_out(lat);
            n_tests++;
            if (lat != vl[i]) begin n_fail++; $display("FAIL op%0d_latency: got %0d expected %0d", i, lat, vl[i]); end
            n_tests++;
            if (dif.result !== ve[i]) begin n_fail++; $display("FAIL op%0d_result: got %h expected %h", i, dif.result, ve[i]); end
            take_out();
        end
    endtask

    task automatic test_special();
        logic [63:0] va [7] = '{64'd5, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_8000_0000,
                                64'h0000_0000_8000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        logic [63:0] vb [7] = '{64'd0, 64'd0, 64'd0, 64'h0000_0000_FFFF_FFFF,
                                64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        logic        vs [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        vr [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        vw [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [63:0] ve [7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9,
                                64'hFFFF_FFFF_8000_0000, 64'd0, 64'h8000_0000_0000_0000, 64'd0};
        int lat;
        for (int i = 0; i < 7; i++) begin
            issue(va[i], vb[i], vs[i], vr[i], vw[i]);
            wait_out(lat);
            n_tests++;
            if (lat != 1) begin n_fail++; $display("FAIL special%0d_latency: got %0d expected 1", i, lat); end
            n_tests++;
            if (dif.result !== ve[i]) begin n_fail++; $display("FAIL special%0d_result: got %h expected %h", i, dif.result, ve[i]); end
            take_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(64'd9, 64'd3, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        n_tests++;
        if (lat != 65) begin n_fail++; $display("FAIL bp_latency: got %0d expected 65", lat); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if (dif.result !== 64'd3 || dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got result=%h out_valid=%b in_ready=%b expected result=3 out_valid=1 in_ready=0",
                         i, dif.result, dif.out_valid, dif.in_ready);
            end
        end
        // Release the result and offer a new request in the same cycle.
        @(negedge clk);
        dif.out_ready = 1'b1;
        dif.op1 = 64'd20; dif.op2 = 64'd4;
        dif.div_signed = 1'b0; dif.is_rem = 1'b0; dif.inst_32bit = 1'b0;
        dif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        dif.out_ready = 1'b0;
        n_tests++;
        if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle_after_handshake: got in_ready=%b out_valid=%b busy=%b expected 1 0 0",
                     dif.in_ready, dif.out_valid, busy);
        end
        @(posedge clk);
        #1;
        dif.in_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept: got busy=%b expected 1", busy); end
        wait_out(lat);
        n_tests++;
        if (lat != 65 || dif.result !== 64'd5) begin
            n_fail++;
            $display("FAIL bp_second_op: got lat=%0d result=%h expected lat=65 result=5", lat, dif.result);
        end
        take_out();
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        issue(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_calc_idle: got busy=%b in_ready=%b out_valid=%b expected 0 1 0",
                     busy, dif.in_ready, dif.out_valid);
        end
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (dif.out_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL flush_no_out_valid: got %0d valid cycles expected 0", seen); end

        // flush wins over a simultaneous request
        @(negedge clk);
        flush = 1'b1;
        dif.op1 = 64'd8; dif.op2 = 64'd2; dif.div_signed = 1'b0; dif.is_rem = 1'b0; dif.inst_32bit = 1'b0;
        dif.in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        dif.in_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_priority: got busy=%b expected 0", busy); end

        // flush in DONE drops the held result
        issue(64'd5, 64'd0, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_tests++;
        if (dif.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_done: got out_valid=%b busy=%b expected 0 0", dif.out_valid, busy);
        end

        issue(64'd9, 64'd3, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        n_tests++;
        if (lat != 65 || dif.result !== 64'd3) begin
            n_fail++;
            $display("FAIL flush_followup: got lat=%0d result=%h expected lat=65 result=3", lat, dif.result);
        end
        take_out();
    endtask

    task automatic test_reset_mid_op();
        issue(64'd77, 64'd5, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || dif.out_valid !== 1'b0 || dif.result !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: got busy=%b out_valid=%b result=%h expected 0 0 0",
                     busy, dif.out_valid, dif.result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef EXU_DIV_PERF_CNT_EN
    task automatic test_perf();
        int lat;
        // counters were cleared by the previous reset; flushed ops must not count
        issue(64'd50, 64'd5, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        take_out();
        issue(64'd50, 64'd5, 1'b0, 1'b0, 1'b1);
        wait_out(lat);
        take_out();
        issue(64'd50, 64'd0, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        take_out();
        issue(64'd50, 64'd5, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (perf_ops !== 64'd3) begin n_fail++; $display("FAIL perf_ops: got %0d expected 3", perf_ops); end
        n_tests++;
        if (perf_cycles !== 64'd96) begin n_fail++; $display("FAIL perf_cycles: got %0d expected 96", perf_cycles); end
    endtask
`endif

    initial begin
        dif.in_valid   = 1'b0;
        dif.op1        = '0;
        dif.op2        = '0;
        dif.div_signed = 1'b0;
        dif.is_rem     = 1'b0;
        dif.inst_32bit = 1'b0;
        dif.out_ready  = 1'b0;

        test_reset();
        test_basic_ops();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
`ifdef EXU_DIV_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
